fp_sqrt_iter: RTL and testbench

//   Parametrised IEEE-754 square root unit for the FPU execute stage. Supports any

---
 rtl/fp_sqrt_iter_if.sv | 27 ++
 rtl/fp_sqrt_iter.sv | 232 +++++++++++++++++++++++
 tb/tb_fp_sqrt_iter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_sqrt_iter_if.sv
// fp_sqrt_iter_if: handshake bundle for the iterative square-root unit.
//   in_valid/in_ready/operand : operand channel (producer -> unit)
//   out_valid/out_ready       : result channel (unit -> consumer)
//   result, flag_nv, flag_nx  : result word and IEEE flags, valid with out_valid
// Modports: master = producer/consumer side, slave = the unit.
interface fp_sqrt_iter_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operand;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_nv;
    logic         flag_nx;

    modport master (
        output in_valid, operand, out_ready,
        input  in_ready, out_valid, result, flag_nv, flag_nx
    );

    modport slave (
        input  in_valid, operand, out_ready,
        output in_ready, out_valid, result, flag_nv, flag_nx
    );
endinterface

// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: IEEE-754 square root, any binary format, subnormal inputs,
// round-to-nearest-even, flags nv/nx. Restoring digit recurrence resolving
// BITS_PER_CYCLE root bits per cycle.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-low reset
//   bus        fp_sqrt_iter_if.slave (operand in, result/flags out)
//   dbg_state  current FSM state (IDLE=0 NORM=1 ITER=2 ROUND=3 OUT=4)
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The operand is taken only in IDLE; the result, once out_valid rises,
// stays unchanged until the edge on which out_ready is high.
module fp_sqrt_iter #(
    parameter int EXP_W          = 8,
    parameter int MAN_W          = 23,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_sqrt_iter_if.slave        bus,
    output logic [2:0]           dbg_state
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int ITERS = (MAN_W + 2 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int NB    = ITERS * BITS_PER_CYCLE;   // root bits actually produced
    localparam int EXTRA = NB - (MAN_W + 2);         // bits below guard, folded into sticky
    localparam int BIAS  = 2 ** (EXP_W - 1) - 1;
    localparam int XW    = 2 * NB;                   // radicand shift register
    localparam int RW    = NB + 2;                   // partial remainder
    localparam int EW    = EXP_W + 2;                // signed unbiased exponent
    localparam int CW    = $clog2(ITERS + 1);

    localparam logic [W-1:0]  QNAN       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [NB-1:0] EXTRA_MASK = NB'((64'd1 << EXTRA) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NORM  = 3'd1,
        S_ITER  = 3'd2,
        S_ROUND = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t state, state_n;

    logic [W-1:0]     opnd;
    logic [XW-1:0]    x_r;
    logic [NB-1:0]    q_r;
    logic [RW-1:0]    rem_r;
    logic [EXP_W-1:0] exp_r;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     result_r;
    logic             nv_r, nx_r;

    // Operand decode and special-case override
    logic             op_sign;
    logic [EXP_W-1:0] op_exp;
    logic [MAN_W-1:0] op_man;
    logic             exp_max, exp_zero, man_zero, is_nan, is_zero, special;
    logic [W-1:0]     sp_res;
    logic             sp_nv;

    assign op_sign  = opnd[W-1];
    assign op_exp   = opnd[W-2 -: EXP_W];
    assign op_man   = opnd[MAN_W-1:0];
    assign exp_max  = &op_exp;
    assign exp_zero = (op_exp == '0);
    assign man_zero = (op_man == '0);
    assign is_nan   = exp_max && !man_zero;
    assign is_zero  = exp_zero && man_zero;
    // Remaining specials: +inf (exp_max) and any negative nonzero value.
    assign special  = exp_max || is_zero || op_sign;

    always_comb begin
        sp_res = QNAN;
        sp_nv  = 1'b0;
        if (is_nan) begin
            sp_nv = !op_man[MAN_W-1];      // signalling NaN
        end else if (is_zero) begin
            sp_res = opnd;                 // keeps the sign of zero
        end else if (op_sign) begin
            sp_nv = 1'b1;
        end else begin
            sp_res = opnd;                 // +inf
        end
    end

    // Normalisation: bring the significand to 1.f and make the exponent even
    logic [MAN_W:0]          sig, sig_n;
    int                      msb, lz;
    logic signed [EW-1:0]    e_un, e_adj;
    logic [XW-1:0]           x_init;
    logic [EXP_W-1:0]        exp_res;

    always_comb begin
        sig = {1'b0, op_man};
        msb = 0;
        for (int i = 0; i <= MAN_W; i++) begin
            if (sig[i]) msb = i;
        end
        lz = MAN_W - msb;
        if (exp_zero) begin
            sig_n = sig << lz;
            e_un  = EW'(1 - BIAS - lz);
        end else begin
            sig_n = {1'b1, op_man};
            e_un  = EW'(int'(op_exp) - BIAS);
        end
        // X = radicand * 2^(2*(NB-1)); an odd exponent doubles the radicand
        // instead of halving, so the root keeps its leading 1 in the top bit.
        x_init = {sig_n, {(XW-MAN_W-1){1'b0}}};
        if (e_un[0]) begin
            e_adj = e_un - EW'(1);
        end else begin
            e_adj  = e_un;
            x_init = x_init >> 1;
        end
        exp_res = EXP_W'((e_adj >>> 1) + EW'(BIAS));
    end

    // One cycle of restoring recurrence
    logic [XW-1:0] x_n;
    logic [NB-1:0] q_n;
    logic [RW-1:0] rem_n;
    logic [RW+1:0] rem_w, trial;

    always_comb begin
        x_n   = x_r;
        q_n   = q_r;
        rem_n = rem_r;
        rem_w = '0;
        trial = '0;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            rem_w = {rem_n, x_n[XW-1 -: 2]};
            trial = {2'b00, q_n, 2'b01};
            if (rem_w >= trial) begin
                rem_w = rem_w - trial;
                q_n   = {q_n[NB-2:0], 1'b1};
            end else begin
                q_n   = {q_n[NB-2:0], 1'b0};
            end
            rem_n = rem_w[RW-1:0];
            x_n   = x_n << 2;
        end
    end

    // Round to nearest even; q_r holds {hidden, fraction, guard, extra}
    logic             guard, sticky, round_up, carry;
    logic [MAN_W-1:0] frac_rnd;
    logic [EXP_W-1:0] exp_rnd;
    logic [W-1:0]     rnd_res;
    logic             rnd_nx;

    always_comb begin
        guard    = q_r[EXTRA];
        sticky   = (rem_r != '0) || ((q_r & EXTRA_MASK) != '0);
        round_up = guard && (sticky || q_r[EXTRA+1]);
        // The hidden bit is always 1, so a carry out of the fraction means 2.0.
        {carry, frac_rnd} = {1'b0, q_r[EXTRA+1 +: MAN_W]} + (MAN_W+1)'(round_up);
        exp_rnd  = carry ? exp_r + EXP_W'(1) : exp_r;
        rnd_res  = {1'b0, exp_rnd, frac_rnd};
        rnd_nx   = guard || sticky;
    end

    // FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.in_valid) state_n = S_NORM;
            S_NORM:  state_n = special ? S_OUT : S_ITER;
            S_ITER:  if (cnt == CW'(ITERS - 1)) state_n = S_ROUND;
            S_ROUND: state_n = S_OUT;
            S_OUT:   if (bus.out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opnd     <= '0;
            x_r      <= '0;
            q_r      <= '0;
            rem_r    <= '0;
            exp_r    <= '0;
            cnt      <= '0;
            result_r <= '0;
            nv_r     <= 1'b0;
            nx_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) opnd <= bus.operand;
                S_NORM: begin
                    if (special) begin
                        result_r <= sp_res;
                        nv_r     <= sp_nv;
                        nx_r     <= 1'b0;
                    end else begin
                        x_r   <= x_init;
                        q_r   <= '0;
                        rem_r <= '0;
                        exp_r <= exp_res;
                        cnt   <= '0;
                    end
                end
                S_ITER: begin
                    x_r   <= x_n;
                    q_r   <= q_n;
                    rem_r <= rem_n;
                    cnt   <= cnt + CW'(1);
                end
                S_ROUND: begin
                    result_r <= rnd_res;
                    nv_r     <= 1'b0;
                    nx_r     <= rnd_nx;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE) && rst;
    assign bus.out_valid = (state == S_OUT);
    assign bus.result    = result_r;
    assign bus.flag_nv   = nv_r;
    assign bus.flag_nx   = nx_r;
    assign dbg_state     = state;
endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb_fp_sqrt_iter: directed checks of fp_sqrt_iter in binary32 (default) and
// binary16 with two root bits per cycle, plus a real-valued binary16 model.
module tb_fp_sqrt_iter;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    fp_sqrt_iter_if #(.W(32)) bus_a ();
    fp_sqrt_iter_if #(.W(16)) bus_h ();
    logic [2:0] dbg_a, dbg_h;

    fp_sqrt_iter dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_a.slave),
        .dbg_state (dbg_a)
    );

    fp_sqrt_iter #(.EXP_W(5), .MAN_W(10), .BITS_PER_CYCLE(2)) dut_h (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_h.slave),
        .dbg_state (dbg_h)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drivers for the binary32 unit
    task automatic vec_a(input string tag, input logic [31:0] op, input logic [31:0] res,
                         input logic nv, input logic nx, input int lat_exp);
        int guard_cnt = 0;
        int lat = 0;
        while (!bus_a.in_ready && guard_cnt < 100) begin
            @(posedge clk); #1; guard_cnt++;
        end
        bus_a.operand  = op;
        bus_a.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        while (!bus_a.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"},   64'(lat), 64'(lat_exp));
        check({tag, "_res"},   64'(bus_a.result), 64'(res));
        check({tag, "_flags"}, 64'({bus_a.flag_nv, bus_a.flag_nx}), 64'({nv, nx}));
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        check({tag, "_idle"}, 64'({bus_a.out_valid, bus_a.in_ready}), 64'(2'b01));
    endtask

    // Drivers for the binary16 unit
    task automatic vec_h(input string tag, input logic [15:0] op, input logic [15:0] res,
                         input logic nv, input logic nx, input int lat_exp);
        int lat = 0;
        bus_h.operand  = op;
        bus_h.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_h.in_valid = 1'b0;
        while (!bus_h.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"},   64'(lat), 64'(lat_exp));
        check({tag, "_res"},   64'(bus_h.result), 64'(res));
        check({tag, "_flags"}, 64'({bus_h.flag_nv, bus_h.flag_nx}), 64'({nv, nx}));
        bus_h.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_h.out_ready = 1'b0;
    endtask

    // Real-valued binary16 reference for positive normals: returns {nx, result}
    function automatic logic [16:0] half_ref(input logic [15:0] h);
        real v, s, scaled, fl, diff;
        int  e, ef, m;
        v  = 1.0 + real'(h[9:0]) / 1024.0;
        ef = int'(h[14:10]) - 15;
        for (int i = 0; i < ef; i++)  v = v * 2.0;
        for (int i = 0; i < -ef; i++) v = v / 2.0;
        s = $sqrt(v);
        e = 0;
        while (s >= 2.0) begin s = s / 2.0; e++; end
        while (s < 1.0)  begin s = s * 2.0; e--; end
        scaled = s * 1024.0;
        fl     = $floor(scaled);
        diff   = scaled - fl;
        m      = $rtoi(fl);
        if (diff > 0.5 || (diff == 0.5 && (m % 2) == 1)) m++;
        if (m >= 2048) begin m = 1024; e++; end
        half_ref = {diff != 0.0, 1'b0, 5'(e + 15), 10'(m - 1024)};
    endfunction

    initial begin
        logic [15:0] hop;
        logic [16:0] href;
        int          bp_bad;
        n_pass  = 0;
        n_total = 0;
        rst = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.operand = '0; bus_a.out_ready = 1'b0;
        bus_h.in_valid = 1'b0; bus_h.operand = '0; bus_h.out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", 64'(bus_a.out_valid), 64'(0));
        check("rst_outputs", 64'({bus_a.result, bus_a.flag_nv, bus_a.flag_nx}), 64'(0));
        check("rst_in_ready", 64'(bus_a.in_ready), 64'(0));
        check("rst_state", 64'(dbg_a), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_release_ready", 64'({bus_a.in_ready, bus_h.in_ready}), 64'(2'b11));

        // binary32 normal operands
        vec_a("a_4p0",   32'h40800000, 32'h40000000, 1'b0, 1'b0, 27);
        vec_a("a_2p0",   32'h40000000, 32'h3FB504F3, 1'b0, 1'b1, 27);
        vec_a("a_1p0",   32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 27);
        vec_a("a_9p0",   32'h41100000, 32'h40400000, 1'b0, 1'b0, 27);
        vec_a("a_3p0",   32'h40400000, 32'h3FDDB3D7, 1'b0, 1'b1, 27);
        vec_a("a_minnrm", 32'h00800000, 32'h20000000, 1'b0, 1'b0, 27);
        // Subnormals
        vec_a("a_minsub", 32'h00000001, 32'h1A3504F3, 1'b0, 1'b1, 27);
        vec_a("a_sub2m127", 32'h00400000, 32'h1FB504F3, 1'b0, 1'b1, 27);

        // Specials
        vec_a("a_neg1",  32'hBF800000, 32'h7FC00000, 1'b1, 1'b0, 1);
        vec_a("a_snan",  32'h7F800001, 32'h7FC00000, 1'b1, 1'b0, 1);
        vec_a("a_negz",  32'h80000000, 32'h80000000, 1'b0, 1'b0, 1);
        vec_a("a_posz",  32'h00000000, 32'h00000000, 1'b0, 1'b0, 1);
        vec_a("a_pinf",  32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 1);
        vec_a("a_ninf",  32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, 1);
        vec_a("a_qnan",  32'h7FFFFFFF, 32'h7FC00000, 1'b0, 1'b0, 1);
        vec_a("a_negsub", 32'h80000001, 32'h7FC00000, 1'b1, 1'b0, 1);

        // Backpressure: hold the result for 10 cycles while a new operand is offered
        bus_a.operand  = 32'h40000000;
        bus_a.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.operand  = 32'h40800000;
        begin
            int lat = 0;
            while (!bus_a.out_valid && lat < 200) begin
                @(posedge clk); #1; lat++;
            end
            check("bp_lat", 64'(lat), 64'(27));
        end
        bp_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({bus_a.out_valid, bus_a.in_ready, bus_a.flag_nv, bus_a.flag_nx, bus_a.result}
                !== {4'b1001, 32'h3FB504F3}) bp_bad++;
            @(posedge clk); #1;
        end
        check("bp_stable_cycles_bad", 64'(bp_bad), 64'(0));
        check("bp_hold_res", 64'(bus_a.result), 64'(32'h3FB504F3));
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        check("bp_release_idle", 64'({bus_a.out_valid, bus_a.in_ready, dbg_a}), 64'({2'b01, 3'd0}));
        bus_a.in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_no_reaccept", 64'(dbg_a), 64'(0));

        // Reset in the middle of ITER
        bus_a.operand  = 32'h40800000;
        bus_a.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus_a.out_valid), 64'(0));
        check("midrst_outputs", 64'({bus_a.result, bus_a.flag_nv, bus_a.flag_nx}), 64'(0));
        check("midrst_state", 64'(dbg_a), 64'(0));
        @(posedge clk); #1 rst = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk); #1;
                if (bus_a.out_valid) seen++;
            end
            check("midrst_discarded", 64'(seen), 64'(0));
        end
        vec_a("a_after_rst", 32'h41100000, 32'h40400000, 1'b0, 1'b0, 27);

        // binary16, two root bits per cycle
        vec_h("h_4p0", 16'h4400, 16'h4000, 1'b0, 1'b0, 8);
        vec_h("h_1p0", 16'h3C00, 16'h3C00, 1'b0, 1'b0, 8);
        vec_h("h_2p0", 16'h4000, 16'h3DA8, 1'b0, 1'b1, 8);
        vec_h("h_3p0", 16'h4200, 16'h3EEE, 1'b0, 1'b1, 8);
        vec_h("h_9p0", 16'h4880, 16'h4200, 1'b0, 1'b0, 8);
        vec_h("h_ninf", 16'hFC00, 16'h7E00, 1'b1, 1'b0, 1);
        for (int i = 0; i < 12; i++) begin
            hop  = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
            href = half_ref(hop);
            vec_h($sformatf("h_rand%0d_%h", i, hop), hop, href[15:0], 1'b0, href[16], 8);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
